dshot_rx: RTL and testbench
===========================

Name: dshot_rx

Overview:
- Parametrised multi-rate DShot frame receiver: DShot150/300/600/1200, selectable at run time.
- Recovers bits by measuring high-pulse width in clk cycles, so it needs no baud generator locked to the input.
- Validates bit timing, frame length and CRC, then presents decoded throttle/command fields with a one-cycle valid strobe.
- Sits between the ESC input pin synchronizer and the motor/command logic.

Parameters:
- CLK_HZ, 16000000, system clock frequency; sets per-rate bit period T = CLK_HZ / rate (integer division).
- SYNC_STAGES, 2, flip-flop stages on din before edge detection (minimum 2).
- CNT_W, 16, width of the pulse/gap timers; must hold 2*T for DShot150.
- ERRCNT_W, 8, width of the saturating CRC-error counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rate_sel  in  2  00=150k, 01=300k, 10=600k, 11=1200k bit/s.
- din  in  1  asynchronous DShot line.
- frame_valid  out  1  one-cycle pulse: new CRC-good frame on outputs.
- throttle  out  11  raw value minus 48; 0 when is_command.
- command  out  6  raw value[5:0] when is_command, else 0.
- is_command  out  1  raw 11-bit value < 48.
- telemetry_req  out  1  frame bit 4.
- crc_error  out  1  one-cycle pulse: 16 bits received, CRC mismatch.
- frame_error  out  1  one-cycle pulse: timing violation or truncated frame.
- crc_err_cnt  out  ERRCNT_W  saturating count of crc_error pulses.
- busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, bit counter 0, timers 0.
- Timing constants: T_sel = CLK_HZ / rate for the selected rate; bit-decision threshold TH = T_sel/2; minimum valid high MIN = T_sel/8.
- rate_sel is latched on the IDLE->HIGH transition and held for the whole frame. Changes mid-frame have no effect until the next frame.
- Edges are detected on the synchronised din only.
- States:
  - IDLE: a rising edge goes to HIGH; hi_cnt=1, bitcnt=0, shift=0.
  - HIGH: hi_cnt increments each cycle.
    - Falling edge: if hi_cnt < MIN, frame_error and go to IDLE. Otherwise shift in the bit (1 if hi_cnt >= TH, else 0, MSB first) and bitcnt++.
    - If that was bit 15, go to CHECK; else go to LOW with lo_cnt=1.
    - If hi_cnt reaches T_sel while high: frame_error, go to IDLE.
  - LOW: lo_cnt increments each cycle.
    - Rising edge: if hi_cnt+lo_cnt (the bit period) < T_sel - T_sel/4, frame_error and go to IDLE. Otherwise go to HIGH with hi_cnt=1.
    - If lo_cnt reaches T_sel (gap before 16 bits): frame_error, go to IDLE.
  - CHECK (1 cycle): compute crc = (v ^ v>>4 ^ v>>8)[3:0] over the 12-bit v = frame[15:4].
    - Match: register throttle/command/is_command/telemetry_req and pulse frame_valid.
    - Mismatch: pulse crc_error and increment crc_err_cnt (saturating at all-ones; no wrap).
    - Always go to IDLE.
- Latency: frame_valid or crc_error is high in the cycle after CHECK, i.e. 2 clk after the synchronised falling edge of bit 15 is detected.
- Decoded outputs hold their last good values. They are never altered by crc_error or frame_error.
- Simultaneous timer expiry and edge in the same cycle: the edge wins.
- A rising edge during CHECK is ignored; the next frame needs a fresh rising edge in IDLE.
- Reset mid-frame: immediate abort, all outputs to 0, no error pulse.

Optional Feature:
- Macro: DSHOT_BIDIR_EN.
- Defined: bidirectional DShot. The line idles high and is inverted internally after synchronization. The expected CRC is the bitwise inverse (~crc[3:0]).
- Undefined: normal polarity, non-inverted CRC. No inversion logic is present.

Decomposition:
- Package dshot_pkg holds:
  - rate_sel encodings and the rate table (150000, 300000, 600000, 1200000);
  - FRAME_BITS=16, VALUE_W=11, CMD_MAX=47;
  - state enum;
  - the CRC function.
- Reuse the existing synchronizer.
- One sub-module, dshot_pulse_meter, holds the edge detect, hi_cnt/lo_cnt and timeout flags. dshot_rx keeps the FSM, shift register and decode.

Test Plan:
- Frame 0x82C6 at DShot600 (T=26, TH=13; 1-bit high 20, 0-bit high 10) -> frame_valid once, throttle=998, is_command=0, telemetry_req=0.
- Frame 0x00BB at DShot150 (T=106; 1-bit high 80, 0-bit high 40) -> frame_valid, is_command=1, command=5, telemetry_req=1, throttle=0.
- Frame 0x82C7 -> crc_error pulse, crc_err_cnt 0->1, no frame_valid, outputs retain previous values. Repeat 300 times -> crc_err_cnt stays 255.
- 10 valid bits, then line low for 30 cycles at DShot600 -> frame_error pulse, busy falls, no frame_valid.
- rate_sel switched from 600 to 150 at bit 8 of a DShot600 frame 0x82C6 -> frame still decodes correctly. Reset asserted at bit 12 of the next frame -> all outputs 0 the following cycle.
- DSHOT_BIDIR_EN defined: inverted-line frame 0x82C9 -> frame_valid, throttle=998. Frame 0x82C6 -> crc_error.

Source files
------------

// File: rtl/dshot_pkg.sv
// dshot_pkg: shared constants, rate table, FSM state type and CRC helper for the DShot receiver.
package dshot_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned VALUE_W    = 11;
    localparam int unsigned CMD_W      = 6;
    localparam int unsigned CMD_MAX    = 47;
    localparam int unsigned CRC_W      = 4;
    localparam int unsigned CRC_DATA_W = FRAME_BITS - CRC_W;

    localparam logic [1:0] RATE_SEL_150  = 2'b00;
    localparam logic [1:0] RATE_SEL_300  = 2'b01;
    localparam logic [1:0] RATE_SEL_600  = 2'b10;
    localparam logic [1:0] RATE_SEL_1200 = 2'b11;

    localparam int unsigned RATE_HZ_150  = 150000;
    localparam int unsigned RATE_HZ_300  = 300000;
    localparam int unsigned RATE_HZ_600  = 600000;
    localparam int unsigned RATE_HZ_1200 = 1200000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HIGH  = 2'd1,
        S_LOW   = 2'd2,
        S_CHECK = 2'd3
    } state_e;

    // Bit period in clk cycles for a given rate selection.
    function automatic int unsigned bit_period(input logic [1:0] sel, input int unsigned clk_hz);
        case (sel)
            RATE_SEL_300:  return clk_hz / RATE_HZ_300;
            RATE_SEL_600:  return clk_hz / RATE_HZ_600;
            RATE_SEL_1200: return clk_hz / RATE_HZ_1200;
            default:       return clk_hz / RATE_HZ_150;
        endcase
    endfunction

    // Nibble-fold checksum over the 12-bit value+telemetry field.
    function automatic logic [CRC_W-1:0] dshot_crc(input logic [CRC_DATA_W-1:0] v);
        logic [CRC_DATA_W-1:0] x;
        x = v ^ (v >> 4) ^ (v >> 8);
        return x[CRC_W-1:0];
    endfunction

endpackage

// File: rtl/dshot_pulse_meter.sv
// dshot_pulse_meter: input synchronizer, edge detect and high/low pulse timers.
// With DSHOT_BIDIR_EN defined the line idles high and is inverted after synchronization.
module dshot_pulse_meter
    import dshot_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_i,
    input  state_e           state_i,
    input  logic [CNT_W-1:0] t_sel_i,
    output logic             rise_c_o,
    output logic             fall_c_o,
    output logic [CNT_W-1:0] hi_cnt_o,
    output logic [CNT_W-1:0] lo_cnt_o,
    output logic             hi_tmo_c_o,
    output logic             lo_tmo_c_o
);

`ifdef DSHOT_BIDIR_EN
    localparam logic SYNC_RST = 1'b1;
`else
    localparam logic SYNC_RST = 1'b0;
`endif

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   line_c;
    logic                   line_prev_q;
    logic [CNT_W-1:0]       hi_cnt_q;
    logic [CNT_W-1:0]       lo_cnt_q;

    // Synchronizer resets to the idle line level so no edge is seen on reset release.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {SYNC_STAGES{SYNC_RST}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end

`ifdef DSHOT_BIDIR_EN
    assign line_c = ~sync_q[SYNC_STAGES-1];
`else
    assign line_c = sync_q[SYNC_STAGES-1];
`endif

    always_ff @(posedge clk) begin
        if (reset) line_prev_q <= 1'b0;
        else       line_prev_q <= line_c;
    end

    assign rise_c_o = line_c & ~line_prev_q;
    assign fall_c_o = ~line_c & line_prev_q;

    // Counters start at 1 on the edge that opens a phase, so they equal the phase width at its closing edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_cnt_q <= '0;
            lo_cnt_q <= '0;
        end else if (rise_c_o && (state_i == S_IDLE || state_i == S_LOW)) begin
            hi_cnt_q <= CNT_W'(1);
        end else if (fall_c_o && state_i == S_HIGH) begin
            lo_cnt_q <= CNT_W'(1);
        end else if (state_i == S_HIGH) begin
            hi_cnt_q <= hi_cnt_q + CNT_W'(1);
        end else if (state_i == S_LOW) begin
            lo_cnt_q <= lo_cnt_q + CNT_W'(1);
        end
    end

    assign hi_cnt_o   = hi_cnt_q;
    assign lo_cnt_o   = lo_cnt_q;
    assign hi_tmo_c_o = (hi_cnt_q >= t_sel_i);
    assign lo_tmo_c_o = (lo_cnt_q >= t_sel_i);

endmodule

// File: rtl/dshot_rx.sv
// dshot_rx: multi-rate DShot frame receiver; checks timing and CRC, presents decoded fields.
// Define DSHOT_BIDIR_EN for bidirectional DShot (inverted line, inverted CRC).
module dshot_rx
    import dshot_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 16000000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ERRCNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          rate_sel,
    input  logic                din,
    output logic                frame_valid,
    output logic [VALUE_W-1:0]  throttle,
    output logic [CMD_W-1:0]    command,
    output logic                is_command,
    output logic                telemetry_req,
    output logic                crc_error,
    output logic                frame_error,
    output logic [ERRCNT_W-1:0] crc_err_cnt,
    output logic                busy
);

    localparam int unsigned T_150  = bit_period(RATE_SEL_150, CLK_HZ);
    localparam int unsigned T_300  = bit_period(RATE_SEL_300, CLK_HZ);
    localparam int unsigned T_600  = bit_period(RATE_SEL_600, CLK_HZ);
    localparam int unsigned T_1200 = bit_period(RATE_SEL_1200, CLK_HZ);
    localparam int unsigned BITCNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(FRAME_BITS - 1);

    state_e                 state_q;
    logic [1:0]             rate_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [FRAME_BITS-1:0]  shift_d;
    logic [BITCNT_W-1:0]    bitcnt_q;
    logic                   frame_valid_q;
    logic                   crc_error_q;
    logic                   frame_error_q;
    logic                   busy_q;
    logic                   is_command_q;
    logic                   telemetry_req_q;
    logic [VALUE_W-1:0]     throttle_q;
    logic [CMD_W-1:0]       command_q;
    logic [ERRCNT_W-1:0]    crc_err_cnt_q;

    logic [CNT_W-1:0]       t_sel_c;
    logic [CNT_W-1:0]       th_c;
    logic [CNT_W-1:0]       min_c;
    logic [CNT_W-1:0]       per_min_c;
    logic [CNT_W:0]         period_c;
    logic [CNT_W-1:0]       hi_cnt;
    logic [CNT_W-1:0]       lo_cnt;
    logic                   rise_c;
    logic                   fall_c;
    logic                   hi_tmo_c;
    logic                   lo_tmo_c;
    logic [VALUE_W-1:0]     raw_c;
    logic                   is_cmd_c;
    logic [CRC_W-1:0]       crc_exp_c;
    logic                   crc_ok_c;

    dshot_pulse_meter #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) u_meter (
        .clk        (clk),
        .reset      (reset),
        .din_i      (din),
        .state_i    (state_q),
        .t_sel_i    (t_sel_c),
        .rise_c_o   (rise_c),
        .fall_c_o   (fall_c),
        .hi_cnt_o   (hi_cnt),
        .lo_cnt_o   (lo_cnt),
        .hi_tmo_c_o (hi_tmo_c),
        .lo_tmo_c_o (lo_tmo_c)
    );

    // Bit period for the rate latched at frame start.
    always_comb begin
        case (rate_q)
            RATE_SEL_300:  t_sel_c = CNT_W'(T_300);
            RATE_SEL_600:  t_sel_c = CNT_W'(T_600);
            RATE_SEL_1200: t_sel_c = CNT_W'(T_1200);
            default:       t_sel_c = CNT_W'(T_150);
        endcase
    end

    assign th_c      = t_sel_c >> 1;
    assign min_c     = t_sel_c >> 3;
    assign per_min_c = t_sel_c - (t_sel_c >> 2);
    assign period_c  = {1'b0, hi_cnt} + {1'b0, lo_cnt};
    assign shift_d   = {shift_q[FRAME_BITS-2:0], (hi_cnt >= th_c)};

    assign raw_c    = shift_q[FRAME_BITS-1 -: VALUE_W];
    assign is_cmd_c = (raw_c <= VALUE_W'(CMD_MAX));
`ifdef DSHOT_BIDIR_EN
    assign crc_exp_c = ~dshot_crc(shift_q[FRAME_BITS-1:CRC_W]);
`else
    assign crc_exp_c = dshot_crc(shift_q[FRAME_BITS-1:CRC_W]);
`endif
    assign crc_ok_c = (shift_q[CRC_W-1:0] == crc_exp_c);

    // Frame FSM; an edge always takes priority over a timer expiry in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            rate_q          <= '0;
            shift_q         <= '0;
            bitcnt_q        <= '0;
            frame_valid_q   <= 1'b0;
            crc_error_q     <= 1'b0;
            frame_error_q   <= 1'b0;
            busy_q          <= 1'b0;
            is_command_q    <= 1'b0;
            telemetry_req_q <= 1'b0;
            throttle_q      <= '0;
            command_q       <= '0;
            crc_err_cnt_q   <= '0;
        end else begin
            frame_valid_q <= 1'b0;
            crc_error_q   <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (rise_c) begin
                        state_q  <= S_HIGH;
                        rate_q   <= rate_sel;
                        shift_q  <= '0;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                    end
                end
                S_HIGH: begin
                    if (fall_c) begin
                        if (hi_cnt < min_c) begin
                            frame_error_q <= 1'b1;
                            state_q       <= S_IDLE;
                            busy_q        <= 1'b0;
                        end else begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + BITCNT_W'(1);
                            state_q  <= (bitcnt_q == LAST_BIT) ? S_CHECK : S_LOW;
                        end
                    end else if (hi_tmo_c) begin
                        frame_error_q <= 1'b1;
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                    end
                end
                S_LOW: begin
                    if (rise_c) begin
                        if (period_c < {1'b0, per_min_c}) begin
                            frame_error_q <= 1'b1;
                            state_q       <= S_IDLE;
                            busy_q        <= 1'b0;
                        end else begin
                            state_q <= S_HIGH;
                        end
                    end else if (lo_tmo_c) begin
                        frame_error_q <= 1'b1;
                        state_q       <= S_IDLE;
                        busy_q        <= 1'b0;
                    end
                end
                S_CHECK: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (crc_ok_c) begin
                        frame_valid_q   <= 1'b1;
                        is_command_q    <= is_cmd_c;
                        telemetry_req_q <= shift_q[CRC_W];
                        throttle_q      <= is_cmd_c ? '0 : raw_c - VALUE_W'(CMD_MAX + 1);
                        command_q       <= is_cmd_c ? raw_c[CMD_W-1:0] : '0;
                    end else begin
                        crc_error_q <= 1'b1;
                        if (crc_err_cnt_q != {ERRCNT_W{1'b1}}) crc_err_cnt_q <= crc_err_cnt_q + ERRCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign frame_valid   = frame_valid_q;
    assign throttle      = throttle_q;
    assign command       = command_q;
    assign is_command    = is_command_q;
    assign telemetry_req = telemetry_req_q;
    assign crc_error     = crc_error_q;
    assign frame_error   = frame_error_q;
    assign crc_err_cnt   = crc_err_cnt_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_dshot_rx.sv
// tb_dshot_rx: self-checking bench for dshot_rx with a frame-level reference model.
// Honours DSHOT_BIDIR_EN (line inverted, CRC inverted) when compiled with it.
module tb_dshot_rx;

    localparam int unsigned CLK_HZ = 16000000;
    localparam logic [1:0] RS_150 = 2'b00, RS_300 = 2'b01, RS_600 = 2'b10, RS_1200 = 2'b11;
`ifdef DSHOT_BIDIR_EN
    localparam logic [15:0] F_600 = 16'h82C9, F_150 = 16'h00B4, F_BAD = 16'h82C6;
`else
    localparam logic [15:0] F_600 = 16'h82C6, F_150 = 16'h00BB, F_BAD = 16'h82C7;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  rate_sel;
    logic        din;
    logic        frame_valid;
    logic [10:0] throttle;
    logic [5:0]  command;
    logic        is_command;
    logic        telemetry_req;
    logic        crc_error;
    logic        frame_error;
    logic [7:0]  crc_err_cnt;
    logic        busy;

    dshot_rx #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(2), .CNT_W(16), .ERRCNT_W(8)) dut (
        .clk(clk), .reset(reset), .rate_sel(rate_sel), .din(din),
        .frame_valid(frame_valid), .throttle(throttle), .command(command),
        .is_command(is_command), .telemetry_req(telemetry_req), .crc_error(crc_error),
        .frame_error(frame_error), .crc_err_cnt(crc_err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int fv_cnt = 0, ce_cnt = 0, fe_cnt = 0, fv_cyc = -1, last_fall_cyc = 0;
    always @(negedge clk) begin
        if (frame_valid) begin fv_cnt <= fv_cnt + 1; fv_cyc <= cyc; end
        if (crc_error)   ce_cnt <= ce_cnt + 1;
        if (frame_error) fe_cnt <= fe_cnt + 1;
    end

    int n_tests = 0, n_fail = 0;

    // Reference model state: decoded fields and error count as the spec defines them.
    int exp_thr = 0, exp_cmd = 0, exp_cnt = 0;
    bit exp_isc = 0, exp_tel = 0;

    function automatic int rate_hz(input logic [1:0] r);
        case (r)
            RS_300:  return 300000;
            RS_600:  return 600000;
            RS_1200: return 1200000;
            default: return 150000;
        endcase
    endfunction

    function automatic int hi_len(input logic [1:0] r, input logic b);
        case (r)
            RS_300:  return b ? 40 : 20;
            RS_600:  return b ? 20 : 10;
            RS_1200: return b ? 10 : 5;
            default: return b ? 80 : 40;
        endcase
    endfunction

    function automatic int ref_crc(input int v);
        int c;
        c = (v ^ (v / 16) ^ (v / 256)) % 16;
`ifdef DSHOT_BIDIR_EN
        c = 15 - c;
`endif
        return c;
    endfunction

    function automatic logic [15:0] make_frame(input int value, input bit tel, input bit good);
        int v, c;
        v = value * 2 + int'(tel);
        c = ref_crc(v);
        if (!good) c = c ^ (1 + int'($urandom % 15));
        return 16'(v * 16 + c);
    endfunction

    task automatic model_frame(input logic [15:0] f, output bit good);
        int v, raw;
        v = int'(f) / 16;
        good = ((int'(f) % 16) == ref_crc(v));
        if (good) begin
            raw = int'(f) / 32;
            exp_tel = bit'(v % 2);
            exp_isc = (raw < 48);
            exp_cmd = exp_isc ? raw : 0;
            exp_thr = exp_isc ? 0 : raw - 48;
        end else if (exp_cnt < 255) begin
            exp_cnt++;
        end
    endtask

    task automatic drive(input logic lvl);
`ifdef DSHOT_BIDIR_EN
        din = ~lvl;
`else
        din = lvl;
`endif
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Sends nbits MSB-first with period T of line_rate; rate_sel is switched before bit sw_at.
    task automatic send_bits(input logic [15:0] f, input logic [1:0] line_rate, input int nbits,
                             input int sw_at, input logic [1:0] sw_rate);
        int t, hi;
        t = CLK_HZ / rate_hz(line_rate);
        for (int i = 0; i < nbits; i++) begin
            if (i == sw_at) rate_sel = sw_rate;
            hi = hi_len(line_rate, f[15 - i]);
            @(negedge clk); drive(1'b1);
            repeat (hi) @(negedge clk);
            drive(1'b0);
            last_fall_cyc = cyc;
            if (i < nbits - 1) repeat (t - hi - 1) @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rate_sel = RS_150; drive(1'b0);
        wait_cycles(3);
        n_tests++;
        if ({frame_valid, throttle, command, is_command, telemetry_req, crc_error, frame_error, crc_err_cnt, busy} !== '0) begin
            n_fail++; $display("FAIL reset_in: outputs=%h want 0", {frame_valid, throttle, command, is_command, telemetry_req, crc_error, frame_error, crc_err_cnt, busy});
        end
        reset = 1'b0;
        wait_cycles(4);
        n_tests++;
        if ({frame_valid, throttle, command, is_command, telemetry_req, crc_error, frame_error, crc_err_cnt, busy} !== '0) begin
            n_fail++; $display("FAIL reset_out: outputs=%h want 0", {frame_valid, throttle, command, is_command, telemetry_req, crc_error, frame_error, crc_err_cnt, busy});
        end
    endtask

    task automatic test_valid_600();
        int fv0, ce0; bit good;
        fv0 = fv_cnt; ce0 = ce_cnt;
        model_frame(F_600, good);
        rate_sel = RS_600;
        send_bits(F_600, RS_600, 16, -1, RS_600);
        wait_cycles(8);
        n_tests++;
        if (fv_cnt - fv0 !== 1 || ce_cnt - ce0 !== 0) begin
            n_fail++; $display("FAIL v600_pulses: valid=%0d crcerr=%0d want 1 0", fv_cnt - fv0, ce_cnt - ce0);
        end
        n_tests++;
        if (fv_cyc - last_fall_cyc !== 4) begin
            n_fail++; $display("FAIL v600_latency: got %0d want 4", fv_cyc - last_fall_cyc);
        end
        n_tests++;
        if (throttle !== 11'd998 || is_command !== 1'b0 || telemetry_req !== 1'b0 || command !== 6'd0) begin
            n_fail++; $display("FAIL v600_decode: thr=%0d isc=%0b tel=%0b cmd=%0d want 998 0 0 0", throttle, is_command, telemetry_req, command);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL v600_busy: got %0b want 0", busy); end
    endtask

    task automatic test_command_150();
        int fv0; bit good;
        fv0 = fv_cnt;
        model_frame(F_150, good);
        rate_sel = RS_150;
        send_bits(F_150, RS_150, 16, -1, RS_150);
        wait_cycles(8);
        n_tests++;
        if (fv_cnt - fv0 !== 1) begin n_fail++; $display("FAIL c150_count: got %0d want 1", fv_cnt - fv0); end
        n_tests++;
        if (is_command !== 1'b1 || command !== 6'd5 || telemetry_req !== 1'b1 || throttle !== 11'd0) begin
            n_fail++; $display("FAIL c150_decode: isc=%0b cmd=%0d tel=%0b thr=%0d want 1 5 1 0", is_command, command, telemetry_req, throttle);
        end
    endtask

    task automatic test_crc_error();
        int fv0, ce0; bit good;
        fv0 = fv_cnt; ce0 = ce_cnt;
        model_frame(F_BAD, good);
        rate_sel = RS_600;
        send_bits(F_BAD, RS_600, 16, -1, RS_600);
        wait_cycles(8);
        n_tests++;
        if (ce_cnt - ce0 !== 1 || fv_cnt - fv0 !== 0) begin
            n_fail++; $display("FAIL crc_pulses: crcerr=%0d valid=%0d want 1 0", ce_cnt - ce0, fv_cnt - fv0);
        end
        n_tests++;
        if (crc_err_cnt !== 8'd1) begin n_fail++; $display("FAIL crc_cnt1: got %0d want 1", crc_err_cnt); end
        n_tests++;
        if ({throttle, command, is_command, telemetry_req} !== {11'(exp_thr), 6'(exp_cmd), exp_isc, exp_tel}) begin
            n_fail++; $display("FAIL crc_hold: thr=%0d cmd=%0d isc=%0b tel=%0b want %0d %0d %0b %0b",
                               throttle, command, is_command, telemetry_req, exp_thr, exp_cmd, exp_isc, exp_tel);
        end
        rate_sel = RS_1200;
        for (int i = 1; i < 300; i++) begin
            model_frame(F_BAD, good);
            send_bits(F_BAD, RS_1200, 16, -1, RS_1200);
            wait_cycles(1);
        end
        wait_cycles(8);
        n_tests++;
        if (crc_err_cnt !== 8'(exp_cnt) || exp_cnt != 255) begin
            n_fail++; $display("FAIL crc_saturate: got %0d want 255", crc_err_cnt);
        end
        n_tests++;
        if (ce_cnt - ce0 !== 300 || fv_cnt - fv0 !== 0) begin
            n_fail++; $display("FAIL crc_burst: crcerr=%0d valid=%0d want 300 0", ce_cnt - ce0, fv_cnt - fv0);
        end
    endtask

    task automatic test_frame_error();
        int fv0, fe0;
        fv0 = fv_cnt; fe0 = fe_cnt;
        rate_sel = RS_600;
        send_bits(F_600, RS_600, 10, -1, RS_600);
        wait_cycles(40);
        n_tests++;
        if (fe_cnt - fe0 !== 1 || fv_cnt - fv0 !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL gap_error: ferr=%0d valid=%0d busy=%0b want 1 0 0", fe_cnt - fe0, fv_cnt - fv0, busy);
        end
        @(negedge clk); drive(1'b1);
        repeat (2) @(negedge clk);
        drive(1'b0);
        wait_cycles(10);
        n_tests++;
        if (fe_cnt - fe0 !== 2 || busy !== 1'b0) begin
            n_fail++; $display("FAIL short_high: ferr=%0d busy=%0b want 2 0", fe_cnt - fe0, busy);
        end
        @(negedge clk); drive(1'b1);
        repeat (40) @(negedge clk);
        drive(1'b0);
        wait_cycles(10);
        n_tests++;
        if (fe_cnt - fe0 !== 3 || fv_cnt - fv0 !== 0) begin
            n_fail++; $display("FAIL long_high: ferr=%0d valid=%0d want 3 0", fe_cnt - fe0, fv_cnt - fv0);
        end
    endtask

    task automatic test_rate_switch_reset();
        int fv0, fe0; bit good;
        fv0 = fv_cnt;
        model_frame(F_600, good);
        rate_sel = RS_600;
        send_bits(F_600, RS_600, 16, 8, RS_150);
        wait_cycles(8);
        n_tests++;
        if (fv_cnt - fv0 !== 1 || throttle !== 11'd998 || is_command !== 1'b0) begin
            n_fail++; $display("FAIL rate_switch: valid=%0d thr=%0d isc=%0b want 1 998 0", fv_cnt - fv0, throttle, is_command);
        end
        rate_sel = RS_600;
        fv0 = fv_cnt; fe0 = fe_cnt;
        send_bits(F_600, RS_600, 12, -1, RS_600);
        @(negedge clk); reset = 1'b1;
        wait_cycles(1);
        n_tests++;
        if ({frame_valid, throttle, command, is_command, telemetry_req, crc_error, frame_error, crc_err_cnt, busy} !== '0) begin
            n_fail++; $display("FAIL reset_mid: outputs=%h want 0", {frame_valid, throttle, command, is_command, telemetry_req, crc_error, frame_error, crc_err_cnt, busy});
        end
        reset = 1'b0;
        exp_thr = 0; exp_cmd = 0; exp_isc = 0; exp_tel = 0; exp_cnt = 0;
        wait_cycles(40);
        n_tests++;
        if (fe_cnt - fe0 !== 0 || fv_cnt - fv0 !== 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_quiet: ferr=%0d valid=%0d busy=%0b want 0 0 0", fe_cnt - fe0, fv_cnt - fv0, busy);
        end
    endtask

    task automatic test_random();
        int fv0, ce0, value;
        bit tel, want_good, good;
        logic [1:0] r;
        logic [15:0] f;
        for (int i = 0; i < 12; i++) begin
            r = 2'($urandom % 4);
            value = int'($urandom_range(0, 2047));
            tel = bit'($urandom % 2);
            want_good = ($urandom % 4) != 0;
            f = make_frame(value, tel, want_good);
            model_frame(f, good);
            fv0 = fv_cnt; ce0 = ce_cnt;
            rate_sel = r;
            send_bits(f, r, 16, -1, r);
            wait_cycles(8 + int'($urandom % 8));
            n_tests++;
            if (fv_cnt - fv0 !== int'(good) || ce_cnt - ce0 !== int'(!good)) begin
                n_fail++; $display("FAIL rand%0d_pulses: frame=%h valid=%0d crcerr=%0d want %0d %0d", i, f, fv_cnt - fv0, ce_cnt - ce0, good, !good);
            end
            n_tests++;
            if ({throttle, command, is_command, telemetry_req, crc_err_cnt} !== {11'(exp_thr), 6'(exp_cmd), exp_isc, exp_tel, 8'(exp_cnt)}) begin
                n_fail++; $display("FAIL rand%0d_decode: frame=%h thr=%0d cmd=%0d isc=%0b tel=%0b cnt=%0d want %0d %0d %0b %0b %0d", i, f,
                                   throttle, command, is_command, telemetry_req, crc_err_cnt, exp_thr, exp_cmd, exp_isc, exp_tel, exp_cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fv0;
        bit good;
        logic [15:0] f1, f2;
        f1 = make_frame(int'($urandom_range(48, 2047)), 1'b0, 1'b1);
        f2 = make_frame(int'($urandom_range(0, 47)), 1'b1, 1'b1);
        fv0 = fv_cnt;
        rate_sel = RS_1200;
        model_frame(f1, good);
        send_bits(f1, RS_1200, 16, -1, RS_1200);
        wait_cycles(1);
        model_frame(f2, good);
        send_bits(f2, RS_1200, 16, -1, RS_1200);
        wait_cycles(8);
        n_tests++;
        if (fv_cnt - fv0 !== 2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", fv_cnt - fv0); end
        n_tests++;
        if ({throttle, command, is_command, telemetry_req} !== {11'(exp_thr), 6'(exp_cmd), exp_isc, exp_tel}) begin
            n_fail++; $display("FAIL b2b_decode: thr=%0d cmd=%0d isc=%0b tel=%0b want %0d %0d %0b %0b",
                               throttle, command, is_command, telemetry_req, exp_thr, exp_cmd, exp_isc, exp_tel);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_valid_600();
        test_command_150();
        test_crc_error();
        test_frame_error();
        test_rate_switch_reset();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
